vi_rst_seq: RTL and testbench

Reset sequencer for a multi-domain FPGA design. It waits for a filtered PLL lock, then releases NUM_DOM synchronous domain resets one at a time, in index order, with a programmable delay between releases. On PLL lock loss or a software reset request it re-asserts all domain resets together and restarts the sequence. It sits at the top of the clocking/reset tree and drives per-domain reset synchronizers for downstream blocks.

---
 rtl/vi_rst_pkg.sv | 24 ++
 rtl/vi_sync_bit.sv | 22 ++
 rtl/vi_rst_seq.sv | 144 ++++++++++++++
 tb/tb_vi_rst_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vi_rst_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// Holds the sequencer state encoding and the shared counter width.
package vi_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    RELEASE,
    RUN,
    HOLD
  } state_t;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // One counter serves lock filter, release delay and hold time.
  function automatic int cnt_w(int dly_w, int lock_filt, int hold_cyc);
    int w;
    w = max2(dly_w, $clog2(lock_filt));
    w = max2(w, $clog2(hold_cyc));
    return max2(w, 1);
  endfunction

endpackage

// File: rtl/vi_sync_bit.sv
// Two-flop synchronizer with asynchronous clear.
// Used for PLL lock and for reset deassertion.
module vi_sync_bit (
  input  logic CLK,
  input  logic RST_ASYNC_N,
  input  logic d,
  output logic q
);

  logic [1:0] ff;

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      ff <= 2'b00;
    end else begin
      ff <= {ff[0], d};
    end
  end

  assign q = ff[1];

endmodule

// File: rtl/vi_rst_seq.sv
// Multi-domain reset sequencer: lock filter, ordered release,
// abort on lock loss or software reset.
module vi_rst_seq
  import vi_rst_pkg::*;
#(
  parameter int NUM_DOM   = 4,
  parameter int DLY_W     = 8,
  parameter int LOCK_FILT = 16,
  parameter int HOLD_CYC  = 32
) (
  input  logic                     CLK,
  input  logic                     RST_ASYNC_N,
  input  logic                     PLL_LOCKED,
  input  logic                     SW_RST,
  input  logic [NUM_DOM*DLY_W-1:0] DLY,
  output logic [NUM_DOM-1:0]       DOM_RST_N,
  output logic                     SEQ_DONE,
  output logic                     LOCK_LOST
);

  localparam int CW = cnt_w(DLY_W, LOCK_FILT, HOLD_CYC);
  localparam int IW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [CW-1:0] LF_M1   = CW'(LOCK_FILT - 1);
  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_CYC - 1);
  localparam logic [IW-1:0] LAST    = IW'(NUM_DOM - 1);

  logic rst_n_s;
  logic lk;

  vi_sync_bit u_rst_sync (
    .CLK         (CLK),
    .RST_ASYNC_N (RST_ASYNC_N),
    .d           (1'b1),
    .q           (rst_n_s)
  );

  vi_sync_bit u_lock_sync (
    .CLK         (CLK),
    .RST_ASYNC_N (RST_ASYNC_N),
    .d           (PLL_LOCKED),
    .q           (lk)
  );

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NUM_DOM-1:0]   dom_q, dom_d;
  logic                 done_q, done_d;
  logic                 lost_q, lost_d;
  logic [IW-1:0]        sel_idx;
  logic [DLY_W-1:0]     sel_dly;

  always_ff @(posedge CLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
      lost_q  <= lost_d;
    end
  end

  // Delay field for the domain about to be loaded.
  assign sel_idx = (state_q == RELEASE) ? idx_q + IW'(1) : '0;
  assign sel_dly = DLY[int'(sel_idx)*DLY_W +: DLY_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    done_d  = done_q;
    lost_d  = lost_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (!lk) begin
          cnt_d = '0;
        end else if (cnt_q == LF_M1) begin
          state_d = RELEASE;
          idx_d   = '0;
          cnt_d   = CW'(sel_dly);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          dom_d[idx_q] = 1'b1;
          if (idx_q == LAST) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
            cnt_d = CW'(sel_dly);
          end
        end
      end
      RUN: begin
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = WAIT_LOCK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase
    if (!lk && (state_q == RELEASE || state_q == RUN)) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
      done_d  = 1'b0;
      lost_d  = 1'b1;
    end
    // Software reset overrides a coincident lock loss.
    if (SW_RST && state_q != HOLD) begin
      state_d = HOLD;
      cnt_d   = HOLD_M1;
      idx_d   = '0;
      dom_d   = '0;
      done_d  = 1'b0;
      lost_d  = 1'b0;
    end
  end

  assign DOM_RST_N = dom_q;
  assign SEQ_DONE  = done_q;
  assign LOCK_LOST = lost_q;

endmodule

// File: tb/tb_vi_rst_seq.sv
// Scoreboard bench for vi_rst_seq: expected output-change events
// are queued at stimulus time and matched as outputs change.
module tb_vi_rst_seq;

  logic        CLK = 1'b0;
  logic        RST_ASYNC_N;
  logic        PLL_LOCKED;
  logic        SW_RST;
  logic [31:0] DLY;
  logic [3:0]  DOM_RST_N;
  logic        SEQ_DONE;
  logic        LOCK_LOST;

  vi_rst_seq #(
    .NUM_DOM   (4),
    .DLY_W     (8),
    .LOCK_FILT (16),
    .HOLD_CYC  (32)
  ) dut (
    .CLK         (CLK),
    .RST_ASYNC_N (RST_ASYNC_N),
    .PLL_LOCKED  (PLL_LOCKED),
    .SW_RST      (SW_RST),
    .DLY         (DLY),
    .DOM_RST_N   (DOM_RST_N),
    .SEQ_DONE    (SEQ_DONE),
    .LOCK_LOST   (LOCK_LOST)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    logic [5:0] val;
  } ev_t;

  ev_t        sb_q[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_err = 0;
  bit         mon_en = 1'b0;
  logic [5:0] prev = '0;

  always @(posedge CLK) cyc++;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    logic [5:0] cur;
    ev_t e;
    cur = {DOM_RST_N, SEQ_DONE, LOCK_LOST};
    if (mon_en && cur !== prev) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_change", 32'(cur), 32'(prev));
      end else begin
        e = sb_q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("event_value", 32'(cur), 32'(e.val));
      end
    end
    prev = cur;
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic to_cyc(int n);
    while (cyc < n) step();
  endtask

  task automatic push(int c, logic [3:0] dom, logic sd, logic ll);
    ev_t e;
    e.cyc = c;
    e.val = {dom, sd, ll};
    sb_q.push_back(e);
  endtask

  // Releases for a PLL rise driven after edge r (DLY = 3,0,5,2).
  task automatic push_seq(int r, logic ll, int n);
    int b0, b1, b2, b3;
    b0 = r + 2 + 16 + 3 + 1;
    b1 = b0 + 0 + 1;
    b2 = b1 + 5 + 1;
    b3 = b2 + 2 + 1;
    if (n > 0) push(b0, 4'b0001, 1'b0, ll);
    if (n > 1) push(b1, 4'b0011, 1'b0, ll);
    if (n > 2) push(b2, 4'b0111, 1'b0, ll);
    if (n > 3) push(b3, 4'b1111, 1'b1, ll);
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain", sb_q.size(), 0);
  endtask

  initial begin
    int t;
    RST_ASYNC_N = 1'b0;
    PLL_LOCKED  = 1'b0;
    SW_RST      = 1'b0;
    DLY         = {8'd2, 8'd5, 8'd0, 8'd3};
    step();
    chk("rst_dom", DOM_RST_N, 4'b0000);
    chk("rst_done", SEQ_DONE, 1'b0);
    chk("rst_lost", LOCK_LOST, 1'b0);
    RST_ASYNC_N = 1'b1;
    mon_en = 1'b1;

    // Nominal sequence: bits at 32, 33, 39, 42.
    to_cyc(10);
    PLL_LOCKED = 1'b1;
    push_seq(10, 1'b0, 4);
    drain(100);
    chk("seq_done_run", SEQ_DONE, 1'b1);

    // One-cycle lock drop in RUN, then recovery.
    step();
    t = cyc;
    PLL_LOCKED = 1'b0;
    push(t + 3, 4'b0000, 1'b0, 1'b1);
    step();
    PLL_LOCKED = 1'b1;
    push_seq(t + 1, 1'b1, 2);
    drain(100);

    // Software reset after bit 1 is released.
    t = cyc;
    SW_RST = 1'b1;
    push(t + 1, 4'b0000, 1'b0, 1'b0);
    step();
    SW_RST = 1'b0;
    push_seq(t + 31, 1'b0, 4);
    drain(150);

    // Lock loss, then a 10-cycle glitch that must not qualify.
    step();
    t = cyc;
    PLL_LOCKED = 1'b0;
    push(t + 3, 4'b0000, 1'b0, 1'b1);
    to_cyc(t + 8);
    PLL_LOCKED = 1'b1;
    to_cyc(t + 18);
    PLL_LOCKED = 1'b0;
    to_cyc(t + 24);
    PLL_LOCKED = 1'b1;
    push_seq(t + 24, 1'b1, 4);
    drain(150);

    // Lock loss and software reset seen on the same edge.
    step();
    t = cyc;
    PLL_LOCKED = 1'b0;
    to_cyc(t + 1);
    PLL_LOCKED = 1'b1;
    to_cyc(t + 2);
    SW_RST = 1'b1;
    push(t + 3, 4'b0000, 1'b0, 1'b0);
    to_cyc(t + 3);
    SW_RST = 1'b0;
    push_seq(t + 33, 1'b0, 4);
    drain(150);

    // Async reset mid-sequence, then restart from scratch.
    step();
    t = cyc;
    SW_RST = 1'b1;
    push(t + 1, 4'b0000, 1'b0, 1'b0);
    step();
    SW_RST = 1'b0;
    push_seq(t + 31, 1'b0, 1);
    drain(150);
    mon_en = 1'b0;
    #2;
    RST_ASYNC_N = 1'b0;
    PLL_LOCKED  = 1'b0;
    #1;
    chk("arst_dom", DOM_RST_N, 4'b0000);
    chk("arst_done", SEQ_DONE, 1'b0);
    chk("arst_lost", LOCK_LOST, 1'b0);
    step();
    step();
    RST_ASYNC_N = 1'b1;
    mon_en = 1'b1;
    t = cyc;
    to_cyc(t + 5);
    PLL_LOCKED = 1'b1;
    push_seq(t + 5, 1'b0, 4);
    drain(100);
    repeat (5) step();
    chk("sb_left", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1);
  end

endmodule
